// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//
// Purpose: bundles every signal between the pipeline datapath and the
// hazard_ctrl stall/flush sequencer so the core top level wires them as one
// unit.
//
// Signal summary:
//   Hazard sources (datapath -> sequencer):
//     id_rs1, id_rs2, id_use_rs1, id_use_rs2   ID-stage source operands
//     ex_rd, ex_mem_read                       EX-stage load destination
//     ex_redirect                              EX branch taken / jump
//     ex_mc_op, mc_done                        multi-cycle unit handshake
//     mem_req, mem_ready                       data-memory wait states
//   Pipeline controls (sequencer -> datapath):
//     pc_en, ifid_en, idex_en, exmem_en, memwb_en          load enables
//     ifid_flush, idex_flush, exmem_flush, memwb_flush     bubble inserts
//     mc_start                                             multi-cycle start
//     mc_err                                               sticky MC timeout
//     stall_cycles, flush_events                           perf counters
//
// Modports: master = datapath side, slave = hazard_ctrl.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_redirect;
    logic                  ex_mc_op;
    logic                  mc_done;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_flush;
    logic                  memwb_flush;
    logic                  mc_start;
    logic                  mc_err;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mc_op, mc_done, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mc_start, mc_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_mc_op, mc_done, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mc_start, mc_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose: central stall/flush sequencer of the 5-stage pipeline. It is the
// only source of the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and
// flushes and of the PC enable. It resolves load-use hazards, EX redirects,
// multi-cycle EX operations (start/done handshake with timeout) and
// data-memory wait states.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (0 = in reset)
//   hz     hazard_ctrl_if.slave bundle (hazard sources in, controls out)
//
// Parameters:
//   REG_ADDR_W  register index width
//   MC_TIMEOUT  MC_WAIT cycles before a forced release (>= 2)
//   CNT_W       performance counter width
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles / flush_events are saturating counters
//   undefined -> both counters read as constant 0, no counter flops
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int            TW      = $clog2(MC_TIMEOUT);
    localparam logic [TW-1:0] MC_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MC_WAIT,
        MEM_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         mcCnt_q, mcCnt_d;
    logic                  mcErr_q, mcErr_d;

    logic                  pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic                  ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic                  mcStart;
    logic                  loadUse, memStall, mcRelease;
    logic [REG_ADDR_W-1:0] exRd;

    assign exRd = hz.ex_rd;

    // Load-use: the load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    assign loadUse = hz.ex_mem_read && (exRd != '0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == exRd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == exRd)));

    // Next-state and control decode. MEM_WAIT shares the RUN rule chain: the
    // only difference is that the memory stall condition no longer needs
    // mem_req, so the release cycle (mem_ready = 1) falls straight through
    // to the lower-priority rules without an extra bubble. In MC_WAIT the
    // release cycle lets everything advance and honours a held redirect
    // but never re-issues the multi-cycle start.
    always_comb begin
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        memwbEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        memwbFlush = 1'b0;
        mcStart    = 1'b0;
        state_d    = state_q;
        mcCnt_d    = mcCnt_q;
        mcErr_d    = mcErr_q;
        memStall   = 1'b0;
        mcRelease  = 1'b0;

        case (state_q)
            MC_WAIT: begin
                mcRelease = hz.mc_done || (mcCnt_q == MC_LAST);
                if (mcRelease) begin
                    if (hz.ex_redirect) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end
                    state_d = RUN;
                    mcCnt_d = '0;
                    if (!hz.mc_done) begin
                        mcErr_d = 1'b1;
                    end
                end else begin
                    pcEn       = 1'b0;
                    ifidEn     = 1'b0;
                    idexEn     = 1'b0;
                    exmemFlush = 1'b1;
                    mcCnt_d    = mcCnt_q + TW'(1);
                end
            end
            default: begin
                if (state_q == MEM_WAIT) begin
                    memStall = !hz.mem_ready;
                end else begin
                    memStall = hz.mem_req && !hz.mem_ready;
                end

                if (memStall) begin
                    pcEn       = 1'b0;
                    ifidEn     = 1'b0;
                    idexEn     = 1'b0;
                    exmemEn    = 1'b0;
                    memwbFlush = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (hz.ex_mc_op) begin
                    mcStart    = 1'b1;
                    pcEn       = 1'b0;
                    ifidEn     = 1'b0;
                    idexEn     = 1'b0;
                    exmemFlush = 1'b1;
                    state_d    = MC_WAIT;
                    mcCnt_d    = '0;
                end else if (hz.ex_redirect) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                    state_d   = RUN;
                end else if (loadUse) begin
                    pcEn      = 1'b0;
                    ifidEn    = 1'b0;
                    idexFlush = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Sequencer state: mode, multi-cycle timeout counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            mcCnt_q <= '0;
            mcErr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcCnt_q <= mcCnt_d;
            mcErr_q <= mcErr_d;
        end
    end

    // Controls are forced inactive for as long as reset is held, without
    // waiting for a clock edge.
    assign hz.pc_en       = reset & pcEn;
    assign hz.ifid_en     = reset & ifidEn;
    assign hz.idex_en     = reset & idexEn;
    assign hz.exmem_en    = reset & exmemEn;
    assign hz.memwb_en    = reset & memwbEn;
    assign hz.ifid_flush  = reset & ifidFlush;
    assign hz.idex_flush  = reset & idexFlush;
    assign hz.exmem_flush = reset & exmemFlush;
    assign hz.memwb_flush = reset & memwbFlush;
    assign hz.mc_start    = reset & mcStart;
    assign hz.mc_err      = mcErr_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] flushCnt_q;

    // Saturating perf counters: stalled-PC cycles and redirect flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (!pcEn && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
            if (ifidFlush && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cycles = stallCnt_q;
    assign hz.flush_events = flushCnt_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Purpose: self-checking bench for hazard_ctrl. Directed steps cover reset,
// load-use, redirect, multi-cycle op, MC timeout, memory wait and reset
// during MC_WAIT; a randomized phase follows. A behavioural model of the
// pipeline controller predicts every control output each cycle.
// Honours HAZARD_PERF_CNT_EN for the counter expectations.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam int MC_TO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hzIf ();

    hazard_ctrl #(
        .REG_ADDR_W(5),
        .MC_TIMEOUT(MC_TO),
        .CNT_W     (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hzIf)
    );

    int compared   = 0;
    int mismatched = 0;

    // Staged stimulus for the next cycle.
    logic [4:0] sRs1, sRs2, sRd;
    logic       sUse1, sUse2, sMemRead, sRedirect, sMcOp, sMcDone, sMemReq, sMemReady;

    // Behavioural model: which wait the pipeline is in and how long it has
    // been frozen on the multi-cycle unit.
    bit         mInMc, mInMem, mErr;
    int         mMcWaited;
    longint     mStall, mFlush;
    bit         nInMc, nInMem, nErr;
    int         nWaited;
    logic [9:0] expVec;
    bit         havePending;
    longint     stallBase;

    // Clear the staged stimulus to an idle pipeline.
    task automatic setIdle();
        sRs1 = 5'd0; sRs2 = 5'd0; sRd = 5'd0;
        sUse1 = 0; sUse2 = 0; sMemRead = 0; sRedirect = 0;
        sMcOp = 0; sMcDone = 0; sMemReq = 0; sMemReady = 1;
    endtask

    task automatic driveInputs();
        hzIf.id_rs1 = sRs1; hzIf.id_rs2 = sRs2; hzIf.ex_rd = sRd;
        hzIf.id_use_rs1 = sUse1; hzIf.id_use_rs2 = sUse2;
        hzIf.ex_mem_read = sMemRead; hzIf.ex_redirect = sRedirect;
        hzIf.ex_mc_op = sMcOp; hzIf.mc_done = sMcDone;
        hzIf.mem_req = sMemReq; hzIf.mem_ready = sMemReady;
    endtask

    // Predict this cycle's controls and the model's next situation.
    // Vector order: pc, ifid, idex, exmem, memwb enables; ifid, idex,
    // exmem, memwb flushes; mc_start.
    task automatic modelEval();
        bit pc = 1, ifid = 1, idex = 1, exmem = 1, memwb = 1;
        bit fIfid = 0, fIdex = 0, fExmem = 0, fMemwb = 0, start = 0;
        bit hazard, waitingOnMem;
        hazard = sMemRead && (sRd != 5'd0) &&
                 ((sUse1 && sRs1 == sRd) || (sUse2 && sRs2 == sRd));
        nInMc = mInMc; nInMem = mInMem; nWaited = mMcWaited; nErr = mErr;
        if (mInMc) begin
            if (sMcDone || mMcWaited == MC_TO - 1) begin
                fIfid = sRedirect; fIdex = sRedirect;
                nInMc = 0;
                if (!sMcDone) nErr = 1;
            end else begin
                pc = 0; ifid = 0; idex = 0; fExmem = 1;
                nWaited = mMcWaited + 1;
            end
        end else begin
            waitingOnMem = mInMem ? !sMemReady : (sMemReq && !sMemReady);
            nInMem = waitingOnMem;
            if (waitingOnMem) begin
                pc = 0; ifid = 0; idex = 0; exmem = 0; fMemwb = 1;
            end else if (sMcOp) begin
                start = 1; pc = 0; ifid = 0; idex = 0; fExmem = 1;
                nInMc = 1; nWaited = 0;
            end else if (sRedirect) begin
                fIfid = 1; fIdex = 1;
            end else if (hazard) begin
                pc = 0; ifid = 0; fIdex = 1;
            end
        end
        expVec = {pc, ifid, idex, exmem, memwb, fIfid, fIdex, fExmem, fMemwb, start};
    endtask

    task automatic modelCommit();
        if (!expVec[9] && mStall < 64'hFFFF_FFFF) mStall++;
        if (expVec[4] && mFlush < 64'hFFFF_FFFF) mFlush++;
        mInMc = nInMc; mInMem = nInMem; mMcWaited = nWaited; mErr = nErr;
    endtask

    task automatic modelReset();
        mInMc = 0; mInMem = 0; mErr = 0; mMcWaited = 0;
        mStall = 0; mFlush = 0; havePending = 0;
    endtask

    function automatic logic [9:0] obsVec();
        return {hzIf.pc_en, hzIf.ifid_en, hzIf.idex_en, hzIf.exmem_en, hzIf.memwb_en,
                hzIf.ifid_flush, hzIf.idex_flush, hzIf.exmem_flush, hzIf.memwb_flush,
                hzIf.mc_start};
    endfunction

    task automatic expectBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expectWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic checkOutput(input string tag);
        logic [9:0] obs;
        modelEval();
        obs = obsVec();
        compared++;
        assert (obs === expVec) else begin
            mismatched++;
            $error("[TB] FAIL %s controls: observed %b expected %b", tag, obs, expVec);
        end
        expectBit({tag, ".mc_err"}, hzIf.mc_err, mErr);
`ifdef HAZARD_PERF_CNT_EN
        expectWord({tag, ".stall"}, hzIf.stall_cycles, 32'(mStall));
        expectWord({tag, ".flush"}, hzIf.flush_events, 32'(mFlush));
`else
        expectWord({tag, ".stall"}, hzIf.stall_cycles, 32'd0);
        expectWord({tag, ".flush"}, hzIf.flush_events, 32'd0);
`endif
    endtask

    // One pipeline cycle: close the previous cycle on the rising edge, then
    // apply the staged inputs and check well before the next edge.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        if (havePending) modelCommit();
        #1;
        driveInputs();
        #1;
        checkOutput(tag);
        havePending = 1;
    endtask

    task automatic checkResetState(input string tag);
        expectWord({tag, ".controls"}, 32'(obsVec()), 32'd0);
        expectBit({tag, ".mc_err"}, hzIf.mc_err, 1'b0);
        expectWord({tag, ".stall"}, hzIf.stall_cycles, 32'd0);
        expectWord({tag, ".flush"}, hzIf.flush_events, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        modelReset();
        setIdle();
        driveInputs();
        #3;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        setIdle();
        applyStimulus("idle0");
        applyStimulus("idle1");

        // Load-use on rs1 stalls exactly one cycle.
        sMemRead = 1; sRd = 5'd5; sRs1 = 5'd5; sUse1 = 1;
        applyStimulus("loadUse");
        expectBit("loadUse.pc_en", hzIf.pc_en, 1'b0);
        expectBit("loadUse.ifid_en", hzIf.ifid_en, 1'b0);
        expectBit("loadUse.idex_flush", hzIf.idex_flush, 1'b1);
        setIdle();
        applyStimulus("afterLoadUse");
        expectBit("afterLoadUse.pc_en", hzIf.pc_en, 1'b1);

        // Destination x0 never stalls.
        sMemRead = 1; sRd = 5'd0; sRs1 = 5'd0; sUse1 = 1;
        applyStimulus("loadUseX0");
        expectBit("loadUseX0.pc_en", hzIf.pc_en, 1'b1);

        // Redirect overrides a simultaneous load-use.
        sMemRead = 1; sRd = 5'd5; sRs2 = 5'd5; sUse2 = 1; sRedirect = 1;
        applyStimulus("redirLoadUse");
        expectBit("redirLoadUse.pc_en", hzIf.pc_en, 1'b1);
        expectBit("redirLoadUse.ifid_flush", hzIf.ifid_flush, 1'b1);
        expectBit("redirLoadUse.idex_flush", hzIf.idex_flush, 1'b1);
        setIdle();
        applyStimulus("idle2");

        // Multi-cycle op completing four cycles after the start pulse.
        sMcOp = 1;
        applyStimulus("mcStart");
        expectBit("mcStart.mc_start", hzIf.mc_start, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("mcFrozen");
            expectBit("mcFrozen.mc_start", hzIf.mc_start, 1'b0);
            expectBit("mcFrozen.exmem_flush", hzIf.exmem_flush, 1'b1);
        end
        sMcDone = 1;
        applyStimulus("mcRelease");
        expectBit("mcRelease.pc_en", hzIf.pc_en, 1'b1);
        expectBit("mcRelease.exmem_flush", hzIf.exmem_flush, 1'b0);
        setIdle();
        applyStimulus("afterMc");
        expectBit("afterMc.mc_err", hzIf.mc_err, 1'b0);

        // Timeout: start, seven frozen cycles, forced release, sticky error.
        sMcOp = 1; sRedirect = 1;
        applyStimulus("toStart");
        for (int i = 0; i < MC_TO - 1; i++) begin
            applyStimulus("toFrozen");
            expectBit("toFrozen.pc_en", hzIf.pc_en, 1'b0);
        end
        applyStimulus("toRelease");
        expectBit("toRelease.pc_en", hzIf.pc_en, 1'b1);
        expectBit("toRelease.ifid_flush", hzIf.ifid_flush, 1'b1);
        setIdle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus("afterTimeout");
            expectBit("afterTimeout.mc_err", hzIf.mc_err, 1'b1);
        end

        // Memory wait: three stalled cycles, then a normal advance.
        sMemReq = 1; sMemReady = 0;
        applyStimulus("memWait");
        stallBase = mStall;
        expectBit("memWait.memwb_flush", hzIf.memwb_flush, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus("memWait");
            expectBit("memWait.exmem_en", hzIf.exmem_en, 1'b0);
        end
        sMemReady = 1;
        applyStimulus("memRelease");
        expectBit("memRelease.pc_en", hzIf.pc_en, 1'b1);
        expectBit("memRelease.memwb_flush", hzIf.memwb_flush, 1'b0);
        setIdle();
        applyStimulus("afterMem");
`ifdef HAZARD_PERF_CNT_EN
        expectWord("memStallCount", hzIf.stall_cycles, 32'(stallBase + 3));
`endif

        // Reset asserted in the middle of MC_WAIT.
        sMcOp = 1;
        applyStimulus("rstMcStart");
        applyStimulus("rstMcFrozen");
        #2;
        reset = 1'b0;
        #1;
        checkResetState("midMcReset");
        modelReset();
        setIdle();
        driveInputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("afterReset");
        expectBit("afterReset.pc_en", hzIf.pc_en, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            sRs1      = 5'($urandom_range(0, 7));
            sRs2      = 5'($urandom_range(0, 7));
            sRd       = 5'($urandom_range(0, 7));
            sUse1     = 1'($urandom_range(0, 1));
            sUse2     = 1'($urandom_range(0, 1));
            sMemRead  = 1'($urandom_range(0, 1));
            sRedirect = ($urandom_range(0, 5) == 0);
            sMcOp     = ($urandom_range(0, 9) == 0);
            sMcDone   = ($urandom_range(0, 6) == 0);
            sMemReq   = ($urandom_range(0, 3) == 0);
            sMemReady = ($urandom_range(0, 2) != 0);
            applyStimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
